// File: rtl/mult_div_unit_pkg.sv
// Shared HI/LO multiply/divide definitions: MDOp encodings, default
// cycle counts and a decode helper used by the unit and its datapath.
package mult_div_unit_pkg;

    localparam logic [2:0] md_nop   = 3'd0;
    localparam logic [2:0] md_mult  = 3'd1;
    localparam logic [2:0] md_multu = 3'd2;
    localparam logic [2:0] md_div   = 3'd3;
    localparam logic [2:0] md_divu  = 3'd4;
    localparam logic [2:0] md_mthi  = 3'd5;
    localparam logic [2:0] md_mtlo  = 3'd6;
    localparam logic [2:0] md_rsvd  = 3'd7;

    localparam int md_mult_cycles_dflt = 5;
    localparam int md_div_cycles_dflt  = 10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic md_is_long(input logic [2:0] op);
        logic long_s;
        case (op)
            md_mult, md_multu, md_div, md_divu: long_s = 1'b1;
            default:                            long_s = 1'b0;
        endcase
        return long_s;
    endfunction

    // True for the two divide flavours.
    function automatic logic md_is_div(input logic [2:0] op);
        logic div_s;
        case (op)
            md_div, md_divu: div_s = 1'b1;
            default:         div_s = 1'b0;
        endcase
        return div_s;
    endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// Combinational HI/LO datapath: maps A, B and MDOp to {hi, lo} including
// the signed/unsigned multiply, truncating divide, divide-by-zero and
// signed-overflow behaviour. Non-arithmetic codes produce zero.
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  md_op,
    output logic [63:0] result
);

    logic [63:0] smul_s;
    logic [63:0] umul_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        b_zero_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] b_mag_safe_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] mquo_s;
    logic [31:0] mrem_s;
    logic [31:0] squo_s;
    logic [31:0] srem_s;

    assign smul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign umul_s = {32'd0, a} * {32'd0, b};

    assign a_neg_s  = a[31];
    assign b_neg_s  = b[31];
    assign b_zero_s = (b == 32'd0);

    // Signed divide works on magnitudes; 0x80000000 has no positive
    // counterpart but its magnitude is still 0x80000000 as unsigned, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign a_mag_s      = a_neg_s ? (~a + 32'd1) : a;
    assign b_mag_s      = b_neg_s ? (~b + 32'd1) : b;
    assign b_safe_s     = b_zero_s ? 32'd1 : b;
    assign b_mag_safe_s = b_zero_s ? 32'd1 : b_mag_s;

    assign uquo_s = a / b_safe_s;
    assign urem_s = a % b_safe_s;
    assign mquo_s = a_mag_s / b_mag_safe_s;
    assign mrem_s = a_mag_s % b_mag_safe_s;

    // Quotient truncates toward zero, remainder follows the dividend sign.
    assign squo_s = (a_neg_s ^ b_neg_s) ? (~mquo_s + 32'd1) : mquo_s;
    assign srem_s = a_neg_s ? (~mrem_s + 32'd1) : mrem_s;

    // Select the {hi, lo} pair for the requested operation.
    always_comb begin
        result = 64'd0;
        case (md_op)
            md_mult:  result = smul_s;
            md_multu: result = umul_s;
            md_div: begin
                if (b_zero_s) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {srem_s, squo_s};
                end
            end
            md_divu: begin
                if (b_zero_s) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {urem_s, uquo_s};
                end
            end
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit. Long operations compute their result at issue
// into shadow registers and commit it to HI/LO after a fixed busy window,
// so HI/LO never show a partial result. mthi/mtlo write in one edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = md_mult_cycles_dflt,
    parameter int DIV_CYCLES  = md_div_cycles_dflt
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_run  = 1'b1;

    localparam logic [3:0] mult_cnt_c = 4'(MULT_CYCLES);
    localparam logic [3:0] div_cnt_c  = 4'(DIV_CYCLES);

    logic [0:0]  state_r,     state_nxt_s;
    logic [3:0]  cnt_r,       cnt_nxt_s;
    logic [31:0] hi_r,        hi_nxt_s;
    logic [31:0] lo_r,        lo_nxt_s;
    logic [31:0] shadow_hi_r, shadow_hi_nxt_s;
    logic [31:0] shadow_lo_r, shadow_lo_nxt_s;
    logic [63:0] result_s;

    md_compute u_compute (
        .a      (A),
        .b      (B),
        .md_op  (MDOp),
        .result (result_s)
    );

    // Next-state logic for the FSM, counter, HI/LO and shadow registers.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        hi_nxt_s        = hi_r;
        lo_nxt_s        = lo_r;
        shadow_hi_nxt_s = shadow_hi_r;
        shadow_lo_nxt_s = shadow_lo_r;
        case (state_r)
            st_idle: begin
                if (start) begin
                    case (MDOp)
                        md_mult, md_multu, md_div, md_divu: begin
                            shadow_hi_nxt_s = result_s[63:32];
                            shadow_lo_nxt_s = result_s[31:0];
                            cnt_nxt_s       = md_is_div(MDOp) ? div_cnt_c : mult_cnt_c;
                            state_nxt_s     = st_run;
                        end
                        md_mthi: hi_nxt_s = A;
                        md_mtlo: lo_nxt_s = A;
                        default: state_nxt_s = st_idle;
                    endcase
                end else begin
                    state_nxt_s = st_idle;
                end
            end
            st_run: begin
                // Any start seen here is ignored: decode is held by stall_req.
                if (cnt_r == 4'd1) begin
                    hi_nxt_s    = shadow_hi_r;
                    lo_nxt_s    = shadow_lo_r;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = st_idle;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = st_idle;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State registers; asynchronous reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= st_idle;
            cnt_r       <= 4'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            shadow_hi_r <= 32'd0;
            shadow_lo_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hi_r        <= hi_nxt_s;
            lo_r        <= lo_nxt_s;
            shadow_hi_r <= shadow_hi_nxt_s;
            shadow_lo_r <= shadow_lo_nxt_s;
        end
    end

    assign busy      = (state_r == st_run);
    assign stall_req = (state_r == st_run) | (start & md_is_long(MDOp));
    assign HI        = hi_r;
    assign LO        = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a behavioural model (arithmetic on
// 64-bit integers plus a remaining-cycles count) is compared against the
// DUT on every falling edge, and literal expectations pin key results.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  MDOp = 3'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_rem = 0;

    mult_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A         (A),
        .B         (B),
        .MDOp      (MDOp),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (op)
            md_mult:  res = 64'(sa * sb);
            md_multu: res = 64'({32'd0, a}) * 64'({32'd0, b});
            md_div: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            md_divu: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic long_op(input logic [2:0] op);
        return (op == md_mult) || (op == md_multu) || (op == md_div) || (op == md_divu);
    endfunction

    // Model: counts down a pending result, otherwise applies a new request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 64'd0; m_rem <= 0;
        end else if (m_rem != 0) begin
            if (m_rem == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
            m_rem <= m_rem - 1;
        end else if (start) begin
            if (long_op(MDOp)) begin
                m_pend <= ref_md(MDOp, A, B);
                m_rem  <= ((MDOp == md_div) || (MDOp == md_divu)) ? ND : NM;
            end else if (MDOp == md_mthi) m_hi <= A;
            else if (MDOp == md_mtlo) m_lo <= A;
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("cyc_busy",  {31'd0, busy}, {31'd0, m_rem != 0});
            chk("cyc_stall", {31'd0, stall_req}, {31'd0, (m_rem != 0) || (start && long_op(MDOp))});
            chk("cyc_hi", HI, m_hi);
            chk("cyc_lo", LO, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #2;
        start = 1'b0; MDOp = md_nop;
    endtask

    // Counts falling edges with busy high, bounded to 40 cycles.
    task automatic busy_len(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            else break;
        end
    endtask

    int cyc;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // 1: mthi / mtlo
        issue(md_mthi, 32'h1234_5678, 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(md_mtlo, 32'h0BAD_F00D, 32'd0);
        chk("mtlo_lo", LO, 32'h0BAD_F00D);
        chk("mtlo_hi", HI, 32'h1234_5678);

        // 2: mult vs multu
        issue(md_mult, 32'hFFFF_FFFF, 32'h0000_0002);
        busy_len(cyc);
        chk("mult_cycles", cyc, NM);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);
        issue(md_multu, 32'hFFFF_FFFF, 32'h0000_0002);
        busy_len(cyc);
        chk("multu_cycles", cyc, NM);
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        // 3: signed divide
        issue(md_div, 32'hFFFF_FFF9, 32'd2);
        busy_len(cyc);
        chk("div_cycles", cyc, ND);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        issue(md_div, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(cyc);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'h0000_0000);

        // 4: divide by zero
        issue(md_divu, 32'd7, 32'd0);
        busy_len(cyc);
        chk("div0_cycles", cyc, ND);
        chk("div0_lo", LO, 32'hFFFF_FFFF);
        chk("div0_hi", HI, 32'h0000_0007);

        // 5: issue while busy is ignored
        issue(md_mult, 32'd3, 32'd4);
        @(posedge clk); #2;
        start = 1'b1; MDOp = md_mtlo; A = 32'hAAAA_AAAA;
        #1 chk("busy_stall", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #2;
        start = 1'b0; MDOp = md_nop;
        busy_len(cyc);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'h0000_000C);

        // 6: asynchronous reset mid-operation
        issue(md_divu, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("nolate_lo", LO, 32'd0);
        chk("nolate_hi", HI, 32'd0);
        chk("nolate_busy", {31'd0, busy}, 32'd0);
        issue(md_mult, 32'd2, 32'd3);
        busy_len(cyc);
        chk("post_cycles", cyc, NM);
        chk("post_lo", LO, 32'd6);
        chk("post_hi", HI, 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
